// File: rtl/tmds_channel_rx.sv
// One TMDS channel decoder: finds the 10-bit character boundary from blanking control tokens, tracks lock, and decodes the characters.
// Define TMDS_RX_TERC4_EN to build the optional TERC4 decoder; when it is undefined, terc4_valid and terc4 are tied to 0.
module tmds_channel_rx #(
  parameter int DWELL_CYCLES = 1024,
  parameter int CTRL_RUN     = 8,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic       clk_pixel,
  input  logic       sys_nrst,
  input  logic [9:0] tmds_word,
  output logic [3:0] bit_offset,
  output logic       locked,
  output logic       ctrl_valid,
  output logic [1:0] ctrl,
  output logic       data_valid,
  output logic [7:0] data,
  output logic       terc4_valid,
  output logic [3:0] terc4,
  output logic [7:0] lost_lock_count
);

  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int RW = $clog2(CTRL_RUN + 1);
  localparam int WW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [RW-1:0] RUN_LAST   = RW'(CTRL_RUN - 1);
  localparam logic [WW-1:0] WD_LAST    = WW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [3:0]    offset_q, offset_d, offset_inc;
  logic [DW-1:0] dwell_q, dwell_d, dwell_sat;
  logic [RW-1:0] run_q, run_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [7:0]    lost_q, lost_d;

  logic [9:0] prev_q, win_q, win_d;
  logic       win_tok;
  logic [1:0] win_ctrl;
  logic [7:0] win_data, d;
  logic       is_ctrl_q;
  logic [1:0] ctrl_q;
  logic [7:0] data_q;

  // The previous word holds the earlier serial bits, so it forms the low half of the 20-bit stream.
  assign win_d = 10'({tmds_word, prev_q} >> offset_q);

  // NOTE: every signal written in an always_comb gets a value on all paths (defaults first), so no latch is inferred.
  always_comb begin
    win_tok  = 1'b0;
    win_ctrl = 2'b00;
    case (win_q)
      10'b1101010100: begin win_tok = 1'b1; win_ctrl = 2'b00; end
      10'b0010101011: begin win_tok = 1'b1; win_ctrl = 2'b01; end
      10'b0101010100: begin win_tok = 1'b1; win_ctrl = 2'b10; end
      10'b1010101011: begin win_tok = 1'b1; win_ctrl = 2'b11; end
      default: ;
    endcase
  end

  always_comb begin
    d           = win_q[9] ? ~win_q[7:0] : win_q[7:0];
    win_data    = 8'h00;
    win_data[0] = d[0];
    for (int i = 1; i < 8; i++)
      win_data[i] = win_q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
  end

  // NOTE: clocked state uses non-blocking assignments, so every register samples values from before the edge.
  always_ff @(posedge clk_pixel or negedge sys_nrst) begin
    if (!sys_nrst) begin
      prev_q    <= '0;
      win_q     <= '0;
      is_ctrl_q <= 1'b0;
      ctrl_q    <= '0;
      data_q    <= '0;
    end else begin
      prev_q    <= tmds_word;
      win_q     <= win_d;
      is_ctrl_q <= win_tok;
      ctrl_q    <= win_ctrl;
      data_q    <= win_data;
    end
  end

  assign offset_inc = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
  // Dwell saturates while confirming, so returning to SEARCH after expiry advances on the next token-free cycle.
  assign dwell_sat  = (dwell_q == DWELL_LAST) ? dwell_q : dwell_q + DW'(1);

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    dwell_d  = dwell_q;
    run_d    = run_q;
    wd_d     = wd_q;
    lost_d   = lost_q;
    case (state_q)
      SEARCH: begin
        if (win_tok) begin
          state_d = CONFIRM;
          run_d   = RW'(1);
          dwell_d = dwell_sat;
        end else if (dwell_q == DWELL_LAST) begin
          offset_d = offset_inc;
          dwell_d  = '0;
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      CONFIRM: begin
        dwell_d = dwell_sat;
        if (!win_tok) begin
          state_d = SEARCH;
          run_d   = '0;
        end else if (run_q == RUN_LAST) begin
          state_d = LOCKED;
          run_d   = '0;
          wd_d    = '0;
        end else begin
          run_d = run_q + RW'(1);
        end
      end
      LOCKED: begin
        if (win_tok) begin
          wd_d = '0;
        end else if (wd_q == WD_LAST) begin
          state_d  = SEARCH;
          offset_d = offset_inc;
          dwell_d  = '0;
          wd_d     = '0;
          lost_d   = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge sys_nrst) begin
    if (!sys_nrst) begin
      state_q  <= SEARCH;
      offset_q <= '0;
      dwell_q  <= '0;
      run_q    <= '0;
      wd_q     <= '0;
      lost_q   <= '0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      dwell_q  <= dwell_d;
      run_q    <= run_d;
      wd_q     <= wd_d;
      lost_q   <= lost_d;
    end
  end

  assign bit_offset      = offset_q;
  assign locked          = (state_q == LOCKED);
  assign ctrl_valid      = locked & is_ctrl_q;
  assign data_valid      = locked & ~is_ctrl_q;
  assign ctrl            = ctrl_q;
  assign data            = data_q;
  assign lost_lock_count = lost_q;

`ifdef TMDS_RX_TERC4_EN
  logic       t_hit, t_hit_q;
  logic [3:0] t_idx, t_idx_q;

  always_comb begin
    t_hit = 1'b1;
    t_idx = 4'h0;
    case (win_q)
      10'b1010011100: t_idx = 4'h0;
      10'b1001100011: t_idx = 4'h1;
      10'b1011100100: t_idx = 4'h2;
      10'b1011100010: t_idx = 4'h3;
      10'b0101110001: t_idx = 4'h4;
      10'b0100011110: t_idx = 4'h5;
      10'b0110001110: t_idx = 4'h6;
      10'b0100111100: t_idx = 4'h7;
      10'b1011001100: t_idx = 4'h8;
      10'b0100111001: t_idx = 4'h9;
      10'b0110011100: t_idx = 4'hA;
      10'b1011000110: t_idx = 4'hB;
      10'b1010001110: t_idx = 4'hC;
      10'b1001110001: t_idx = 4'hD;
      10'b0101100011: t_idx = 4'hE;
      10'b1011000011: t_idx = 4'hF;
      default:        t_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge sys_nrst) begin
    if (!sys_nrst) begin
      t_hit_q <= 1'b0;
      t_idx_q <= '0;
    end else begin
      t_hit_q <= t_hit;
      t_idx_q <= t_idx;
    end
  end

  assign terc4_valid = locked & t_hit_q;
  assign terc4       = t_idx_q;
`else
  assign terc4_valid = 1'b0;
  assign terc4       = 4'h0;
`endif

endmodule

// File: tb/tb_tmds_channel_rx.sv
// Scoreboard bench for tmds_channel_rx: the driver queues expected decodes and a negedge monitor pops and compares them while locked.
// Serial streams are built with a configurable bit shift, so that alignment search, lock loss and relock can be exercised.
module tb_tmds_channel_rx;

  logic       clk_pixel = 1'b0;
  logic       sys_nrst;
  logic [9:0] tmds_word;
  logic [3:0] bit_offset;
  logic       locked, ctrl_valid, data_valid, terc4_valid;
  logic [1:0] ctrl;
  logic [7:0] data, lost_lock_count;
  logic [3:0] terc4;

  tmds_channel_rx dut (
    .clk_pixel(clk_pixel), .sys_nrst(sys_nrst), .tmds_word(tmds_word),
    .bit_offset(bit_offset), .locked(locked), .ctrl_valid(ctrl_valid), .ctrl(ctrl),
    .data_valid(data_valid), .data(data), .terc4_valid(terc4_valid), .terc4(terc4),
    .lost_lock_count(lost_lock_count)
  );

  always #5 clk_pixel = ~clk_pixel;

`ifdef TMDS_RX_TERC4_EN
  localparam bit TERC4_ON = 1'b1;
`else
  localparam bit TERC4_ON = 1'b0;
`endif

  typedef struct {
    int         tag;
    logic       is_ctrl;
    logic [1:0] ctrl;
    logic [7:0] data;
    logic       tv;
    logic [3:0] ti;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         cur_tag = 0;
  int         last_tok_tag = 0;
  int         shift = 0;
  logic [9:0] prev_char = '0;
  bit         watch_off = 0, watch_nolock = 0, off_violation = 0, nolock_violation = 0;

  always @(posedge clk_pixel) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Each call occupies one cycle; the tag is the index of the edge that samples this word.
  task automatic drive(input logic [9:0] ch, input logic is_c, input logic [1:0] c,
                       input logic [7:0] dd, input logic tv, input logic [3:0] ti);
    exp_t e;
    @(negedge clk_pixel);
    tmds_word = 10'({ch, prev_char} >> (10 - shift));
    prev_char = ch;
    cur_tag   = cyc + 1;
    e.tag = cur_tag; e.is_ctrl = is_c; e.ctrl = c; e.data = dd; e.tv = tv; e.ti = ti;
    sb.push_back(e);
    if (is_c) last_tok_tag = cur_tag;
  endtask

  task automatic tok(input int n);
    repeat (n) drive(10'h354, 1'b1, 2'b00, 8'h00, 1'b0, 4'h0);
  endtask

  task automatic vid(input int n);
    repeat (n) drive(10'h100, 1'b0, 2'b00, 8'h00, 1'b0, 4'h0);
  endtask

  task automatic line(input int ntok);
    tok(ntok);
    vid(800 - ntok);
  endtask

  task automatic lines_until_lock(input int max_lines);
    for (int l = 0; l < max_lines; l++) begin
      if (locked) break;
      line(160);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_pixel);
    sys_nrst = 1'b0;
    @(negedge clk_pixel);
    sys_nrst = 1'b1;
  endtask

  // The last token reaches the FSM two edges after it is sampled; the watchdog then needs 4096 token-free edges.
  task automatic lose_lock(input int exp_off, input int exp_cnt);
    int t;
    t = last_tok_tag;
    do vid(1); while (cur_tag < t + 4098);
    check("lock_held_before_timeout", locked, 1'b1);
    vid(1);
    check("lock_dropped_at_timeout", locked, 1'b0);
    check("offset_after_timeout", bit_offset, exp_off);
    check("lost_lock_count", lost_lock_count, exp_cnt);
  endtask

  always @(negedge clk_pixel) begin
    while (sb.size() > 0 && sb[0].tag < cyc - 2) void'(sb.pop_front());
    if (locked) begin
      if (sb.size() > 0 && sb[0].tag == cyc - 2) begin
        mon_e = sb.pop_front();
        check("ctrl_valid", ctrl_valid, mon_e.is_ctrl);
        check("data_valid", data_valid, !mon_e.is_ctrl);
        if (mon_e.is_ctrl) check("ctrl", ctrl, mon_e.ctrl);
        else check("data", data, mon_e.data);
        check("terc4_valid", terc4_valid, mon_e.tv);
        check("terc4", terc4, mon_e.ti);
      end
    end else if (sys_nrst) begin
      check("valids_gated", {ctrl_valid, data_valid, terc4_valid}, 3'b000);
    end
  end

  always @(negedge clk_pixel) begin
    if (watch_off && locked && bit_offset != 4'd3) off_violation = 1'b1;
    if (watch_nolock && locked) nolock_violation = 1'b1;
  end

  initial begin
    #2_000_000;
    n_checks++;
    n_bad++;
    $display("FAIL sim_timeout: got no finish expected finish by 2000000");
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    sys_nrst  = 1'b0;
    tmds_word = '0;
    repeat (3) @(negedge clk_pixel);
    check("reset_offset", bit_offset, 0);
    check("reset_locked", locked, 0);
    check("reset_lost", lost_lock_count, 0);
    check("reset_outputs", {ctrl_valid, ctrl, data_valid, data, terc4_valid, terc4}, 0);
    sys_nrst = 1'b1;

    // Aligned stream: lock exactly nine edges after the first token is sampled.
    vid(5);
    for (int k = 0; k < 12; k++) begin
      tok(1);
      if (k == 9)  check("lock_not_yet", locked, 1'b0);
      if (k == 10) check("lock_after_9", locked, 1'b1);
    end
    check("aligned_offset", bit_offset, 0);
    tok(148);
    vid(640);

    // Watchdog timeout, then relock one bit further on.
    lose_lock(1, 1);
    shift = 1;
    lines_until_lock(4);
    check("relock_shift1", locked, 1'b1);
    check("relock_offset1", bit_offset, 1);

    // Second loss, then reset while confirming at offset 2.
    lose_lock(2, 2);
    shift = 2;
    vid(30);
    tok(6);
    #1 sys_nrst = 1'b0;
    #1;
    check("async_rst_offset", bit_offset, 0);
    check("async_rst_lost", lost_lock_count, 0);
    check("async_rst_outputs", {locked, ctrl_valid, ctrl, data_valid, data, terc4_valid, terc4}, 0);
    @(negedge clk_pixel);
    sys_nrst = 1'b1;
    shift = 0;
    lines_until_lock(2);
    check("restart_lock", locked, 1'b1);
    check("restart_offset0", bit_offset, 0);

    // Stream shifted by 3 bits: search must step through offsets 0-2 without locking.
    do_reset();
    shift = 3;
    watch_off = 1'b1;
    lines_until_lock(12);
    watch_off = 1'b0;
    check("shift3_lock", locked, 1'b1);
    check("shift3_offset", bit_offset, 3);
    check("shift3_no_early_lock", off_violation, 1'b0);
    vid(20);

    // Runs of five tokens are too short: never locks, and the offset keeps advancing.
    do_reset();
    shift = 0;
    watch_nolock = 1'b1;
    for (int n = 1; n <= 3200; n++) begin
      if (((n - 1) % 800) < 5) tok(1);
      else vid(1);
      if (n == 1100) check("short_run_offset1", bit_offset, 1);
      if (n == 2150) check("short_run_offset2", bit_offset, 2);
      if (n == 3200) check("short_run_offset3", bit_offset, 3);
    end
    watch_nolock = 1'b0;
    check("short_run_never_locked", nolock_violation, 1'b0);

    // Directed decode vectors while locked.
    do_reset();
    vid(3);
    tok(20);
    drive(10'h0AB, 1'b1, 2'b01, 8'h00, 1'b0, 4'h0);
    drive(10'h154, 1'b1, 2'b10, 8'h00, 1'b0, 4'h0);
    drive(10'h2AB, 1'b1, 2'b11, 8'h00, 1'b0, 4'h0);
    drive(10'h354, 1'b1, 2'b00, 8'h00, 1'b0, 4'h0);
    drive(10'h100, 1'b0, 2'b00, 8'h00, 1'b0, 4'h0);
    drive(10'h171, 1'b0, 2'b00, 8'h93, TERC4_ON, TERC4_ON ? 4'h4 : 4'h0);
    drive(10'h2CC, 1'b0, 2'b00, 8'hAB, TERC4_ON, TERC4_ON ? 4'h8 : 4'h0);
    drive(10'h000, 1'b0, 2'b00, 8'hFE, 1'b0, 4'h0);
    drive(10'h1FF, 1'b0, 2'b00, 8'h01, 1'b0, 4'h0);
    drive(10'h0FF, 1'b0, 2'b00, 8'hFF, 1'b0, 4'h0);
    drive(10'h255, 1'b0, 2'b00, 8'h00, 1'b0, 4'h0);
    vid(5);
    check("vectors_locked", locked, 1'b1);
    repeat (3) @(negedge clk_pixel);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
